// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared constants, state type and half-period table for the piezo tone generator
package piezo_pkg;

    localparam int                PERIOD_W = 18;
    localparam int                CODE_W   = 6;
    localparam logic [CODE_W-1:0] NOTE_MAX = 6'd48;

    // Half-periods in 50 MHz clocks for C3..B3: round(25e6 / f).
    localparam logic [PERIOD_W-1:0] BASE [12] = '{
        18'd191113, 18'd180386, 18'd170262, 18'd160706,
        18'd151686, 18'd143173, 18'd135137, 18'd127553,
        18'd120394, 18'd113636, 18'd107258, 18'd101238
    };

    typedef enum logic {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_e;

    function automatic logic [PERIOD_W-1:0] base_half_period(input logic [3:0] semi);
        logic [PERIOD_W-1:0] result;
        result = '0;
        if (semi < 4'd12) begin
            result = BASE[semi];
        end
        return result;
    endfunction

endpackage

// File: rtl/piezo_note_lut.sv
// rtl/piezo_note_lut.sv - registered note-code to half-period lookup (0 means silence)
module piezo_note_lut
    import piezo_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CODE_W-1:0]   code_i,
    output logic [PERIOD_W-1:0] period_o
);

    logic [CODE_W-1:0]   idx;
    logic [3:0]          semi;
    logic [1:0]          oct;
    logic [PERIOD_W-1:0] period_d;
    logic [PERIOD_W-1:0] period_q;

    // Each octave above C3 halves the period; codes outside 1..NOTE_MAX are silent.
    always_comb begin
        idx      = code_i - 6'd1;
        semi     = 4'(idx % 6'd12);
        oct      = 2'(idx / 6'd12);
        period_d = '0;
        if ((code_i != '0) && (code_i <= NOTE_MAX)) begin
            period_d = base_half_period(semi) >> oct;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_o = period_q;

endmodule

// File: rtl/piezo_tone_gen.sv
// rtl/piezo_tone_gen.sv - square-wave piezo driver: code register, period lookup, half-period FSM
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] note_code,
    output logic              piezo_out,
    output logic              tone_active
);

    logic [CODE_W-1:0]   code_q;
    logic [PERIOD_W-1:0] period_q;
    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                piezo_q, piezo_d;
    logic                tone_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q <= '0;
        end else begin
            code_q <= note_code;
        end
    end

    piezo_note_lut u_lut (
        .clk      (clk),
        .reset_n  (reset_n),
        .code_i   (code_q),
        .period_o (period_q)
    );

    // period_q is only sampled at reloads, so a new pitch never truncates a running half-period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        piezo_d = piezo_q;
        case (state_q)
            IDLE: begin
                if (period_q != '0) begin
                    state_d = TONE;
                    piezo_d = ~IDLE_LEVEL;
                    cnt_d   = period_q - PERIOD_W'(1);
                end else begin
                    piezo_d = IDLE_LEVEL;
                    cnt_d   = '0;
                end
            end
            TONE: begin
                if (period_q == '0) begin
                    state_d = IDLE;
                    piezo_d = IDLE_LEVEL;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else begin
                    piezo_d = ~piezo_q;
                    cnt_d   = period_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                piezo_d = IDLE_LEVEL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            piezo_q <= IDLE_LEVEL;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            piezo_q <= piezo_d;
            tone_q  <= (state_d == TONE);
        end
    end

    assign piezo_out   = piezo_q;
    assign tone_active = tone_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// tb/tb_piezo_tone_gen.sv - self-checking bench for piezo_tone_gen with a scoreboard queue
module tb_piezo_tone_gen;

    logic       clk;
    logic       clk_en;
    logic       reset_n;
    logic [5:0] note_code;
    logic       piezo_lo, tone_lo;
    logic       piezo_hi, tone_hi;

    int checks;
    int errors;
    int cyc;
    int exp_q[$];
    int t_prev;

    piezo_tone_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .note_code   (note_code),
        .piezo_out   (piezo_lo),
        .tone_active (tone_lo)
    );

    piezo_tone_gen #(.IDLE_LEVEL(1'b1)) dut_hi (
        .clk         (clk),
        .reset_n     (reset_n),
        .note_code   (note_code),
        .piezo_out   (piezo_hi),
        .tone_active (tone_hi)
    );

    always begin
        #10;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic int model_period(input int c);
        int tbl [12];
        tbl = '{191113, 180386, 170262, 160706, 151686, 143173,
                135137, 127553, 120394, 113636, 107258, 101238};
        if (c == 0 || c > 48) return 0;
        return tbl[(c - 1) % 12] >> ((c - 1) / 12);
    endfunction

    task automatic wait_toggle(input int limit, output int t);
        logic last;
        last = piezo_lo;
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (piezo_lo !== last) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        note_code = 6'd0;
        repeat (3) @(negedge clk);
        checks++; if (piezo_lo !== 1'b0) begin errors++; $display("FAIL reset_piezo got %b exp 0", piezo_lo); end
        checks++; if (tone_lo !== 1'b0) begin errors++; $display("FAIL reset_tone got %b exp 0", tone_lo); end
        checks++; if (piezo_hi !== 1'b1) begin errors++; $display("FAIL reset_piezo_hi got %b exp 1", piezo_hi); end
        checks++; if (int'(dut.period_q) !== 0) begin errors++; $display("FAIL reset_period got %0d exp 0", dut.period_q); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lut();
        int e;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(dut.period_q) !== e) begin
                    errors++;
                    $display("FAIL lut_code%0d got %0d exp %0d", i - 2, dut.period_q, e);
                end
            end
            if (i < 64) begin
                note_code = 6'(i);
                exp_q.push_back(model_period(i));
            end
        end
        note_code = 6'd0;
        repeat (4) @(negedge clk);
        checks++; if (tone_lo !== 1'b0) begin errors++; $display("FAIL lut_idle_tone got %b exp 0", tone_lo); end
    endtask

    task automatic test_tone_start();
        int t;
        int e;
        note_code = 6'd48;
        @(negedge clk);
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b0 || tone_lo !== 1'b0) begin errors++; $display("FAIL start_early got %b%b exp 00", piezo_lo, tone_lo); end
        checks++; if (piezo_hi !== 1'b1) begin errors++; $display("FAIL start_early_hi got %b exp 1", piezo_hi); end
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b1 || tone_lo !== 1'b1) begin errors++; $display("FAIL start_edge got %b%b exp 11", piezo_lo, tone_lo); end
        checks++; if (piezo_hi !== 1'b0 || tone_hi !== 1'b1) begin errors++; $display("FAIL start_edge_hi got %b%b exp 01", piezo_hi, tone_hi); end
        t_prev = cyc;
        exp_q.push_back(model_period(48));
        exp_q.push_back(model_period(48));
        while (exp_q.size() > 0) begin
            wait_toggle(13000, t);
            e = exp_q.pop_front();
            checks++;
            if (t - t_prev !== e) begin errors++; $display("FAIL half_period_48 got %0d exp %0d", t - t_prev, e); end
            t_prev = t;
        end
    endtask

    task automatic test_switch();
        int t;
        int e;
        repeat (5) @(negedge clk);
        note_code = 6'd46;
        exp_q.push_back(model_period(48));
        exp_q.push_back(model_period(46));
        while (exp_q.size() > 0) begin
            wait_toggle(15000, t);
            e = exp_q.pop_front();
            checks++;
            if (t - t_prev !== e) begin errors++; $display("FAIL switch_half got %0d exp %0d", t - t_prev, e); end
            t_prev = t;
        end
    endtask

    task automatic test_silence();
        note_code = 6'd55;
        @(negedge clk);
        @(negedge clk);
        checks++; if (tone_lo !== 1'b1) begin errors++; $display("FAIL silence_early got %b exp 1", tone_lo); end
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b0 || tone_lo !== 1'b0) begin errors++; $display("FAIL silence_55 got %b%b exp 00", piezo_lo, tone_lo); end
        checks++; if (piezo_hi !== 1'b1) begin errors++; $display("FAIL silence_55_hi got %b exp 1", piezo_hi); end
        repeat (3) @(negedge clk);
        note_code = 6'd46;
        @(negedge clk);
        note_code = 6'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b1 || tone_lo !== 1'b1) begin errors++; $display("FAIL burst_on got %b%b exp 11", piezo_lo, tone_lo); end
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b0 || tone_lo !== 1'b0) begin errors++; $display("FAIL burst_off got %b%b exp 00", piezo_lo, tone_lo); end
        repeat (5) @(negedge clk);
        checks++; if (piezo_lo !== 1'b0 || tone_lo !== 1'b0) begin errors++; $display("FAIL burst_stuck got %b%b exp 00", piezo_lo, tone_lo); end
    endtask

    task automatic test_async_reset();
        note_code = 6'd46;
        repeat (10) @(negedge clk);
        checks++; if (tone_lo !== 1'b1) begin errors++; $display("FAIL pre_reset_tone got %b exp 1", tone_lo); end
        clk_en = 1'b0;
        #3 reset_n = 1'b0;
        #2;
        checks++; if (piezo_lo !== 1'b0 || tone_lo !== 1'b0) begin errors++; $display("FAIL async_reset got %b%b exp 00", piezo_lo, tone_lo); end
        checks++; if (piezo_hi !== 1'b1 || tone_hi !== 1'b0) begin errors++; $display("FAIL async_reset_hi got %b%b exp 10", piezo_hi, tone_hi); end
        #5 reset_n = 1'b1;
        #3 clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (tone_lo !== 1'b0) begin errors++; $display("FAIL restart_early got %b exp 0", tone_lo); end
        @(negedge clk);
        checks++; if (piezo_lo !== 1'b1 || tone_lo !== 1'b1) begin errors++; $display("FAIL restart got %b%b exp 11", piezo_lo, tone_lo); end
        checks++; if (piezo_hi !== 1'b0) begin errors++; $display("FAIL restart_hi got %b exp 0", piezo_hi); end
    endtask

    initial begin
        clk       = 1'b0;
        clk_en    = 1'b1;
        reset_n   = 1'b0;
        note_code = 6'd0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        test_reset();
        test_lut();
        test_tone_start();
        test_switch();
        test_silence();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
